// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter and the 16x8 FIFO it feeds.
// Contents:
//   FIFO_DW, FIFO_DEPTH  default data width and depth shared with fifo16_8
//   arb_state_t          arbiter state encoding (IDLE, GNT0, GNT1)
package fifo_arb_pkg;

    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fifo16_8.sv
// 16-entry x 8-bit synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   we, din      write strobe and data (ignored while full)
//   re, dout     read strobe (ignored while empty), head-of-queue data
//   full, empty  occupancy flags
module fifo16_8
    import fifo_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [FIFO_DW-1:0] din,
    input  logic               re,
    output logic [FIFO_DW-1:0] dout,
    output logic               full,
    output logic               empty
);

    logic [FIFO_DW-1:0] mem [FIFO_DEPTH];
    logic [3:0]         wp;
    logic [3:0]         rp;
    logic [4:0]         cnt;
    logic               wr;
    logic               rd;

    assign full  = (cnt == 5'(FIFO_DEPTH));
    assign empty = (cnt == 5'd0);
    assign wr    = we & ~full;
    assign rd    = re & ~empty;
    assign dout  = mem[rp];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + 4'd1;
            if (rd) rp <= rp + 4'd1;
            cnt <= cnt + 5'(wr) - 5'(rd);
        end
    end

    // NOTE: storage array is deliberately not reset; the pointers and count
    // define which entries are valid, and a reset here would block RAM mapping.
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end

endmodule

// File: rtl/fifo_level_tracker.sv
// Saturating occupancy counter for a FIFO, driven by observed writes/reads.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   inc       an entry was written this cycle
//   dec       an entry was read this cycle
//   level     current occupancy, 0..DEPTH
module fifo_level_tracker #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   dec,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW = $clog2(DEPTH) + 1;

    // Simultaneous inc and dec cancel; both ends saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (inc && !dec && level != LW'(DEPTH)) begin
            level <= level + LW'(1);
        end else if (dec && !inc && level != '0) begin
            level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO between two valid/ready producers,
// with bounded bursts per grant and a tracked FIFO fill level.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_valid/data/ready         producer 0 handshake (ready = beat accepted)
//   req1_valid/data/ready         producer 1 handshake
//   fifo_we, fifo_din             write side of the FIFO
//   fifo_full, fifo_empty         FIFO flags
//   fifo_re                       copy of the FIFO read strobe, for occupancy
//   grant                         one-hot current owner, 00 when idle
//   level                         tracked FIFO occupancy, 0..DEPTH
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW        = FIFO_DW,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [DW-1:0]          req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [DW-1:0]          req1_data,
    output logic                   req1_ready,
    output logic                   fifo_we,
    output logic [DW-1:0]          fifo_din,
    input  logic                   fifo_full,
    input  logic                   fifo_re,
    input  logic                   fifo_empty,
    output logic [1:0]             grant,
    output logic [$clog2(DEPTH):0] level
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t state, state_nx;
    logic       last, last_nx;
    logic [3:0] burst_cnt, burst_cnt_nx;
    logic       beat0, beat1;
    logic       own_id, own_valid, oth_valid, own_beat;

    // Datapath outputs; reset forces everything quiet even if the state
    // register still holds a grant from before the reset edge.
    always_comb begin
        beat0      = (state == GNT0) & req0_valid & ~fifo_full & ~rst;
        beat1      = (state == GNT1) & req1_valid & ~fifo_full & ~rst;
        req0_ready = beat0;
        req1_ready = beat1;
        fifo_we    = beat0 | beat1;
        fifo_din   = '0;
        grant      = 2'b00;
        if (!rst) begin
            grant = {state == GNT1, state == GNT0};
            if (state == GNT0) fifo_din = req0_data;
            if (state == GNT1) fifo_din = req1_data;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx     = state;
        last_nx      = last;
        burst_cnt_nx = burst_cnt;
        own_id       = (state == GNT1);
        own_valid    = own_id ? req1_valid : req0_valid;
        oth_valid    = own_id ? req0_valid : req1_valid;
        own_beat     = beat0 | beat1;
        unique case (state)
            IDLE: begin
                burst_cnt_nx = '0;
                if (req0_valid && req1_valid) state_nx = last ? GNT0 : GNT1;
                else if (req0_valid)          state_nx = GNT0;
                else if (req1_valid)          state_nx = GNT1;
            end
            GNT0, GNT1: begin
                if (!own_valid || (own_beat && burst_cnt == BURST_LAST)) begin
                    // Hand over without an idle bubble; re-grant self only
                    // when the other side has nothing to send.
                    last_nx      = own_id;
                    burst_cnt_nx = '0;
                    if (oth_valid)      state_nx = own_id ? GNT0 : GNT1;
                    else if (own_valid) state_nx = state;
                    else                state_nx = IDLE;
                end else if (own_beat) begin
                    burst_cnt_nx = burst_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    fifo_level_tracker #(
        .DEPTH (DEPTH)
    ) u_level (
        .clk   (clk),
        .rst   (rst),
        .inc   (fifo_we),
        .dec   (fifo_re & ~fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: fifo_wr_arbiter driving fifo16_8, compared every cycle
// against a queue-based behavioural model, plus directed literal checks.
module tb_fifo_wr_arbiter;

    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0 = '0, d1 = '0;
    int         n0 = 0, n1 = 0;
    int         acc0 = 0, acc1 = 0;
    logic       fifo_re = 1'b0;

    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic       fifo_we, fifo_full, fifo_empty;
    logic [7:0] fifo_din, fifo_dout;
    logic [1:0] grant;
    logic [4:0] level;

    assign req0_valid = (n0 > 0);
    assign req1_valid = (n1 > 0);

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DW(8), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(d0), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(d1), .req1_ready(req1_ready),
        .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .fifo_re(fifo_re), .fifo_empty(fifo_empty),
        .grant(grant), .level(level)
    );

    fifo16_8 u_fifo (
        .clk(clk), .rst(rst), .we(fifo_we), .din(fifo_din), .re(fifo_re),
        .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 none, 0/1 producer; beats: beats accepted in current grant.
    int         owner = -1;
    int         beats = 0;
    int         last  = 1;
    logic [7:0] q[$];
    logic       m_we;
    logic [7:0] m_din;
    bit         chk_en = 0;

    always @(negedge clk) begin
        logic [1:0] e_grant;
        logic       e_r0, e_r1, vx;
        e_grant = 2'b00; e_r0 = 0; e_r1 = 0; m_we = 0; m_din = 8'h00;
        if (!rst && owner >= 0) begin
            vx      = (owner == 1) ? req1_valid : req0_valid;
            e_grant = (owner == 1) ? 2'b10 : 2'b01;
            m_din   = (owner == 1) ? d1 : d0;
            if (vx && q.size() < DEPTH) begin
                m_we = 1;
                if (owner == 1) e_r1 = 1; else e_r0 = 1;
            end
        end
        if (chk_en) begin
            check("grant", grant, e_grant);
            check("fifo_we", fifo_we, m_we);
            check("req0_ready", req0_ready, e_r0);
            check("req1_ready", req1_ready, e_r1);
            check("fifo_din", fifo_din, m_din);
            check("level", level, q.size());
            if (!rst && q.size() != 0) check("fifo_dout", fifo_dout, q[0]);
        end
    end

    always @(posedge clk) begin
        int  x;
        bit  vo, vs;
        if (rst) begin
            owner = -1; beats = 0; last = 1; q.delete();
        end else begin
            if (fifo_re && q.size() != 0) void'(q.pop_front());
            if (m_we) q.push_back(m_din);
            if (owner < 0) begin
                beats = 0;
                if (req0_valid && req1_valid) owner = (last == 0) ? 1 : 0;
                else if (req0_valid)          owner = 0;
                else if (req1_valid)          owner = 1;
            end else begin
                x  = owner;
                vs = (x == 1) ? req1_valid : req0_valid;
                vo = (x == 1) ? req0_valid : req1_valid;
                if (m_we) beats++;
                if (!vs || beats == MAX_BURST) begin
                    last  = x;
                    beats = 0;
                    if (vo)      owner = 1 - x;
                    else if (vs) owner = x;
                    else         owner = -1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [1:0] s_grant;
    logic       s_we, s_r0, s_r1;
    logic [4:0] s_level;
    logic [7:0] got[$];

    // One clock: snapshot outputs mid-cycle, then advance producers whose
    // beat was accepted.
    task automatic step();
        @(negedge clk);
        s_grant = grant; s_we = fifo_we; s_r0 = req0_ready; s_r1 = req1_ready;
        s_level = level;
        @(posedge clk);
        #1;
        if (s_r0) begin n0--; d0++; acc0++; end
        if (s_r1) begin n1--; d1++; acc1++; end
    endtask

    task automatic do_reset();
        rst = 1; n0 = 0; n1 = 0; acc0 = 0; acc1 = 0; fifo_re = 0;
        step();
        rst = 0;
    endtask

    task automatic run_done(input string name, input int budget);
        int c = 0;
        while ((n0 > 0 || n1 > 0) && c < budget) begin step(); c++; end
        check(name, n0 + n1, 0);
    endtask

    task automatic drain(input int n);
        got.delete();
        fifo_re = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got.push_back(fifo_dout);
            @(posedge clk);
            #1;
        end
        fifo_re = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int idle_cnt;
        logic [7:0] e;

        // Reset state
        step();
        chk_en = 1;
        do_reset();
        step();
        check("rst_grant", s_grant, 2'b00);
        check("rst_level", s_level, 0);
        check("rst_we", s_we, 0);

        // 1: single producer, 8 beats across a burst boundary
        n0 = 8; d0 = 8'h01;
        step();
        check("t1_arb_cycle_grant", s_grant, 2'b00);
        step();
        check("t1_first_grant", s_grant, 2'b01);
        check("t1_first_we", s_we, 1);
        run_done("t1_done", 40);
        step();
        check("t1_level", s_level, 8);
        drain(8);
        for (int i = 0; i < 8; i++) check("t1_order", got[i], i + 1);

        // 2: both always valid, alternating 4-beat bursts
        do_reset();
        n0 = 8; d0 = 8'h10; n1 = 8; d1 = 8'h20;
        run_done("t2_done", 60);
        step();
        check("t2_level", s_level, 16);
        drain(16);
        for (int i = 0; i < 16; i++) begin
            e = (((i / 4) % 2 == 0) ? 8'h10 : 8'h20) + 8'((i / 8) * 4 + (i % 4));
            check("t2_order", got[i], e);
        end

        // 3: fill to full, stall, one read frees exactly one slot
        do_reset();
        n0 = 17; d0 = 8'h40;
        c = 0;
        while (acc0 < 16 && c < 40) begin step(); c++; end
        step(); step();
        check("t3_full_level", s_level, 16);
        check("t3_stall_ready", s_r0, 0);
        check("t3_stall_we", s_we, 0);
        check("t3_stall_grant", s_grant, 2'b01);
        fifo_re = 1;
        step();
        check("t3_read_cycle_we", s_we, 0);
        fifo_re = 0;
        step();
        check("t3_refill_we", s_we, 1);
        check("t3_refill_ready", s_r0, 1);
        step();
        check("t3_level_back", s_level, 16);
        check("t3_remaining", n0, 0);

        // 4: concurrent write+read holds level; reads from empty saturate at 0
        do_reset();
        n0 = 8; d0 = 8'h80;
        c = 0;
        while (acc0 < 5 && c < 30) begin step(); c++; end
        fifo_re = 1;
        step(); step(); step();
        fifo_re = 0;
        step();
        check("t4_level_hold", s_level, 5);
        check("t4_remaining", n0, 0);
        drain(5);
        for (int i = 0; i < 5; i++) check("t4_order", got[i], 8'h83 + 8'(i));
        fifo_re = 1;
        step(); step();
        fifo_re = 0;
        step();
        check("t4_empty_level", s_level, 0);

        // 5: reset mid-burst, then tie goes to producer 0
        do_reset();
        n1 = 4; d1 = 8'h30;
        c = 0;
        while (acc1 < 2 && c < 20) begin step(); c++; end
        rst = 1;
        step();
        check("t5_rst_cycle_we", s_we, 0);
        check("t5_rst_cycle_grant", s_grant, 2'b00);
        rst = 0; n1 = 0;
        step();
        check("t5_post_grant", s_grant, 2'b00);
        check("t5_post_level", s_level, 0);
        check("t5_post_we", s_we, 0);
        n0 = 2; d0 = 8'h60; n1 = 2; d1 = 8'h70;
        step();
        step();
        check("t5_tie_grant", s_grant, 2'b01);
        run_done("t5_done", 30);

        // 6: req1 drops after one beat, req0 takes over with no idle cycle
        do_reset();
        n1 = 1; d1 = 8'h50;
        step();
        n0 = 6; d0 = 8'h60;
        step();
        check("t6_p1_grant", s_grant, 2'b10);
        check("t6_p1_beat", s_r1, 1);
        idle_cnt = 0;
        c = 0;
        while (n0 > 0 && c < 30) begin
            step();
            if (s_grant == 2'b00) idle_cnt++;
            c++;
        end
        check("t6_done", n0, 0);
        check("t6_no_idle", idle_cnt, 0);
        step();
        drain(7);
        check("t6_first", got[0], 8'h50);
        for (int i = 1; i < 7; i++) check("t6_order", got[i], 8'h5f + 8'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
